cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits between the three functional units and the complete stage.
- Buffers one finished result per FU and shares the two completion/forwarding ports (port 1, port 2) among the three FUs using rotating round-robin priority.
- Drives registered broadcasts carrying data, physical destination, ROB tag and source FU. The complete stage uses these to mark ROB rows complete and to forward results.
- Pushes back on an FU with a valid/ready handshake while that FU's buffer is occupied.

Parameters:
- DATA_W, 32, result width
- PREG_W, 6, physical register index width
- ROB_W, 4, ROB tag width
- Number of FUs is fixed at 3 and number of ports at 2; these are not parameters.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- flush_i  input  1  synchronous pipeline flush
- cdb_stall_i  input  1  complete stage cannot accept this cycle
- fu{k}_valid_i  input  1  FU k (k=1..3) result valid
- fu{k}_ready_o  output  1  FU k buffer can accept
- fu{k}_data_i  input  DATA_W  FU k result
- fu{k}_dest_i  input  PREG_W  FU k physical destination
- fu{k}_rob_i  input  ROB_W  FU k ROB tag
- cdb{p}_valid_o  output  1  port p (p=1..2) broadcast valid
- cdb{p}_data_o  output  DATA_W  port p result
- cdb{p}_dest_o  output  PREG_W  port p physical destination
- cdb{p}_rob_o  output  ROB_W  port p ROB tag
- cdb{p}_fu_o  output  2  port p source FU (1..3; 0 when port p is idle)

Behaviour:
- State consists of:
  - per-FU hold register: hv[k], data, dest, rob
  - rr pointer, 2 bits, values 0..2 only
  - registered CDB outputs
- Reset (rst_n low, asynchronous): all hv=0; rr=0; all cdb*_valid_o=0, data/dest/rob/fu outputs=0. fu{k}_ready_o is 0 while rst_n is low.
- Grant (combinational on current state):
  - eligible[k] = hv[k] & ~cdb_stall_i & ~flush_i.
  - Scan order is rr, rr+1, rr+2 (mod 3).
  - The first eligible FU takes port 1; the second eligible FU takes port 2; a third waits.
  - Port 2 is never granted unless port 1 is also granted.
- Ready: fu{k}_ready_o = ~flush_i & (~hv[k] | grant[k]). It must not depend on fu{k}_valid_i.
- Hold update at the clock edge:
  - If fu{k}_valid_i & fu{k}_ready_o: load the hold register from the inputs; hv[k]=1.
  - Else if grant[k]: hv[k]=0.
  - Else: hold is unchanged.
  - Grant and refill in the same cycle leaves the new entry held (back-to-back sustained rate: 1 result per FU per cycle while granted).
- CDB output at the clock edge:
  - Port p registers the granted entry with valid=1 and fu=k.
  - Ungranted port: valid=0, fu=0, data/dest/rob=0.
  - Latency from FU handshake to cdb valid is exactly 2 clocks when uncontended.
- rr update: if any grant, rr = (index of the last granted FU + 1) mod 3; otherwise rr is unchanged.
- Stall (cdb_stall_i=1):
  - No grants; all cdb valids go 0 on the next edge.
  - Holds are retained.
  - FUs with empty holds may still load.
- Flush (flush_i=1): priority over everything.
  - Next edge: all hv=0, cdb valids=0, rr=0.
  - Inputs presented during flush are dropped (ready=0).
- All three holds full with no stall: 2 are granted, 1 waits. The waiting FU's ready stays 0 until its hold is granted.
- A dest of 0 is broadcast like any other value; store completions still need the ROB tag.
- Reset asserted mid-operation: all held results are discarded immediately.

Test Plan:
- Reset, then FU1 valid with data=0x0000_0005, dest=6'd12, rob=4'd3: fu1_ready_o=1 → 2 clocks later cdb1_valid_o=1 with data=5, dest=12, rob=3, fu=1; cdb2_valid_o=0; rr=1.
- FU1, FU2 and FU3 all valid in the same cycle, rr=0: next broadcast has port1=FU1, port2=FU2 and rr becomes 2. The following cycle port1=FU3, with FU1/FU2 new entries taking the lower priority.
- FU2 valid every cycle with no contention for 8 cycles: fu2_ready_o held at 1 → 8 consecutive cdb1 broadcasts, in order, with no gaps.
- FU3 result held, cdb_stall_i=1 for 3 cycles: cdb valids stay 0 and fu3_ready_o=0. After stall drops, FU3 is broadcast on port 1 one clock later.
- Holds FU1 and FU2 full, then flush_i pulsed for 1 cycle: no broadcast of those results; ready=0 during the flush cycle; rr=0 afterwards.
- rst_n deasserted low asynchronously mid-cycle while cdb1_valid_o=1: cdb1_valid_o drops to 0 immediately without waiting for a clock edge; all readys=0 until rst_n returns high.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Buffers one finished result per
//               functional unit (3 FUs) and shares two registered broadcast
//               ports among them with rotating round-robin priority.
//               Each FU is back-pressured while its hold buffer is occupied
//               and not being drained.
// Ports       : clk, rst_n            clock / async active-low reset
//               flush_i               synchronous pipeline flush
//               cdb_stall_i           complete stage cannot accept
//               fu{1..3}_valid_i/ready_o/data_i/dest_i/rob_i   FU results
//               cdb{1..2}_valid_o/data_o/dest_o/rob_o/fu_o     broadcasts
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              cdb_stall_i,
    input  logic              fu1_valid_i,
    output logic              fu1_ready_o,
    input  logic [DATA_W-1:0] fu1_data_i,
    input  logic [PREG_W-1:0] fu1_dest_i,
    input  logic [ROB_W-1:0]  fu1_rob_i,
    input  logic              fu2_valid_i,
    output logic              fu2_ready_o,
    input  logic [DATA_W-1:0] fu2_data_i,
    input  logic [PREG_W-1:0] fu2_dest_i,
    input  logic [ROB_W-1:0]  fu2_rob_i,
    input  logic              fu3_valid_i,
    output logic              fu3_ready_o,
    input  logic [DATA_W-1:0] fu3_data_i,
    input  logic [PREG_W-1:0] fu3_dest_i,
    input  logic [ROB_W-1:0]  fu3_rob_i,
    output logic              cdb1_valid_o,
    output logic [DATA_W-1:0] cdb1_data_o,
    output logic [PREG_W-1:0] cdb1_dest_o,
    output logic [ROB_W-1:0]  cdb1_rob_o,
    output logic [1:0]        cdb1_fu_o,
    output logic              cdb2_valid_o,
    output logic [DATA_W-1:0] cdb2_data_o,
    output logic [PREG_W-1:0] cdb2_dest_o,
    output logic [ROB_W-1:0]  cdb2_rob_o,
    output logic [1:0]        cdb2_fu_o
);

    // Increment modulo 3 for FU indices / round-robin pointer.
    function automatic logic [1:0] f_inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Inputs gathered into arrays indexed by FU number minus one.
    logic [2:0]        w_valid_in;
    logic [DATA_W-1:0] w_in_data [3];
    logic [PREG_W-1:0] w_in_dest [3];
    logic [ROB_W-1:0]  w_in_rob  [3];

    assign w_valid_in   = {fu3_valid_i, fu2_valid_i, fu1_valid_i};
    assign w_in_data[0] = fu1_data_i;
    assign w_in_data[1] = fu2_data_i;
    assign w_in_data[2] = fu3_data_i;
    assign w_in_dest[0] = fu1_dest_i;
    assign w_in_dest[1] = fu2_dest_i;
    assign w_in_dest[2] = fu3_dest_i;
    assign w_in_rob[0]  = fu1_rob_i;
    assign w_in_rob[1]  = fu2_rob_i;
    assign w_in_rob[2]  = fu3_rob_i;

    // Hold registers, round-robin pointer and registered broadcast ports.
    logic [2:0]        hv_q, hv_d;
    logic [DATA_W-1:0] data_q [3];
    logic [DATA_W-1:0] data_d [3];
    logic [PREG_W-1:0] dest_q [3];
    logic [PREG_W-1:0] dest_d [3];
    logic [ROB_W-1:0]  rob_q  [3];
    logic [ROB_W-1:0]  rob_d  [3];
    logic [1:0]        rr_q, rr_d;

    logic              cdb_valid_q [2];
    logic              cdb_valid_d [2];
    logic [DATA_W-1:0] cdb_data_q  [2];
    logic [DATA_W-1:0] cdb_data_d  [2];
    logic [PREG_W-1:0] cdb_dest_q  [2];
    logic [PREG_W-1:0] cdb_dest_d  [2];
    logic [ROB_W-1:0]  cdb_rob_q   [2];
    logic [ROB_W-1:0]  cdb_rob_d   [2];
    logic [1:0]        cdb_fu_q    [2];
    logic [1:0]        cdb_fu_d    [2];

    // ------------------------------------------------------------------
    // Grant: scan rr, rr+1, rr+2; first eligible gets port 1, second gets
    // port 2. Port 2 can therefore only be granted when port 1 is.
    // ------------------------------------------------------------------
    logic [1:0] w_ord [3];
    logic [2:0] w_elig;
    logic       w_p_v   [2];
    logic [1:0] w_p_sel [2];
    logic [2:0] w_grant;
    logic [2:0] w_ready;
    logic [2:0] w_load;

    assign w_ord[0] = rr_q;
    assign w_ord[1] = f_inc3(rr_q);
    assign w_ord[2] = f_inc3(f_inc3(rr_q));
    assign w_elig   = hv_q & {3{~cdb_stall_i & ~flush_i}};

    always_comb begin
        w_p_v[0]   = 1'b0;
        w_p_v[1]   = 1'b0;
        w_p_sel[0] = 2'd0;
        w_p_sel[1] = 2'd0;
        for (int j = 0; j < 3; j++) begin
            if (w_elig[w_ord[j]]) begin
                if (!w_p_v[0]) begin
                    w_p_v[0]   = 1'b1;
                    w_p_sel[0] = w_ord[j];
                end else if (!w_p_v[1]) begin
                    w_p_v[1]   = 1'b1;
                    w_p_sel[1] = w_ord[j];
                end
            end
        end
    end

    always_comb begin
        w_grant = 3'b000;
        if (w_p_v[0]) w_grant[w_p_sel[0]] = 1'b1;
        if (w_p_v[1]) w_grant[w_p_sel[1]] = 1'b1;
    end

    // Ready is independent of valid; a buffer being drained this cycle can
    // be refilled in the same cycle. Held low throughout reset.
    assign w_ready     = {3{rst_n & ~flush_i}} & (~hv_q | w_grant);
    assign w_load      = w_valid_in & w_ready;
    assign fu1_ready_o = w_ready[0];
    assign fu2_ready_o = w_ready[1];
    assign fu3_ready_o = w_ready[2];

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        hv_d = hv_q;
        for (int k = 0; k < 3; k++) begin
            data_d[k] = data_q[k];
            dest_d[k] = dest_q[k];
            rob_d[k]  = rob_q[k];
            if (flush_i) begin
                hv_d[k] = 1'b0;
            end else if (w_load[k]) begin
                hv_d[k]   = 1'b1;
                data_d[k] = w_in_data[k];
                dest_d[k] = w_in_dest[k];
                rob_d[k]  = w_in_rob[k];
            end else if (w_grant[k]) begin
                hv_d[k] = 1'b0;
            end
        end

        for (int p = 0; p < 2; p++) begin
            cdb_valid_d[p] = w_p_v[p];
            cdb_data_d[p]  = '0;
            cdb_dest_d[p]  = '0;
            cdb_rob_d[p]   = '0;
            cdb_fu_d[p]    = 2'd0;
            if (w_p_v[p]) begin
                cdb_data_d[p] = data_q[w_p_sel[p]];
                cdb_dest_d[p] = dest_q[w_p_sel[p]];
                cdb_rob_d[p]  = rob_q[w_p_sel[p]];
                cdb_fu_d[p]   = w_p_sel[p] + 2'd1;
            end
        end

        // Pointer moves past the last FU granted this cycle.
        if (flush_i)       rr_d = 2'd0;
        else if (w_p_v[1]) rr_d = f_inc3(w_p_sel[1]);
        else if (w_p_v[0]) rr_d = f_inc3(w_p_sel[0]);
        else               rr_d = rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q <= 3'b000;
            rr_q <= 2'd0;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
                rob_q[k]  <= '0;
            end
            for (int p = 0; p < 2; p++) begin
                cdb_valid_q[p] <= 1'b0;
                cdb_data_q[p]  <= '0;
                cdb_dest_q[p]  <= '0;
                cdb_rob_q[p]   <= '0;
                cdb_fu_q[p]    <= 2'd0;
            end
        end else begin
            hv_q <= hv_d;
            rr_q <= rr_d;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= data_d[k];
                dest_q[k] <= dest_d[k];
                rob_q[k]  <= rob_d[k];
            end
            for (int p = 0; p < 2; p++) begin
                cdb_valid_q[p] <= cdb_valid_d[p];
                cdb_data_q[p]  <= cdb_data_d[p];
                cdb_dest_q[p]  <= cdb_dest_d[p];
                cdb_rob_q[p]   <= cdb_rob_d[p];
                cdb_fu_q[p]    <= cdb_fu_d[p];
            end
        end
    end

    assign cdb1_valid_o = cdb_valid_q[0];
    assign cdb1_data_o  = cdb_data_q[0];
    assign cdb1_dest_o  = cdb_dest_q[0];
    assign cdb1_rob_o   = cdb_rob_q[0];
    assign cdb1_fu_o    = cdb_fu_q[0];
    assign cdb2_valid_o = cdb_valid_q[1];
    assign cdb2_data_o  = cdb_data_q[1];
    assign cdb2_dest_o  = cdb_dest_q[1];
    assign cdb2_rob_o   = cdb_rob_q[1];
    assign cdb2_fu_o    = cdb_fu_q[1];

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        cdb_stall_i;
    logic        fu1_valid_i, fu2_valid_i, fu3_valid_i;
    logic        fu1_ready_o, fu2_ready_o, fu3_ready_o;
    logic [31:0] fu1_data_i, fu2_data_i, fu3_data_i;
    logic [5:0]  fu1_dest_i, fu2_dest_i, fu3_dest_i;
    logic [3:0]  fu1_rob_i, fu2_rob_i, fu3_rob_i;
    logic        cdb1_valid_o, cdb2_valid_o;
    logic [31:0] cdb1_data_o, cdb2_data_o;
    logic [5:0]  cdb1_dest_o, cdb2_dest_o;
    logic [3:0]  cdb1_rob_o, cdb2_rob_o;
    logic [1:0]  cdb1_fu_o, cdb2_fu_o;

    int vectors = 0;
    int miscompares = 0;

    cdb_arbiter #(.DATA_W(32), .PREG_W(6), .ROB_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .cdb_stall_i(cdb_stall_i),
        .fu1_valid_i(fu1_valid_i), .fu1_ready_o(fu1_ready_o), .fu1_data_i(fu1_data_i),
        .fu1_dest_i(fu1_dest_i), .fu1_rob_i(fu1_rob_i),
        .fu2_valid_i(fu2_valid_i), .fu2_ready_o(fu2_ready_o), .fu2_data_i(fu2_data_i),
        .fu2_dest_i(fu2_dest_i), .fu2_rob_i(fu2_rob_i),
        .fu3_valid_i(fu3_valid_i), .fu3_ready_o(fu3_ready_o), .fu3_data_i(fu3_data_i),
        .fu3_dest_i(fu3_dest_i), .fu3_rob_i(fu3_rob_i),
        .cdb1_valid_o(cdb1_valid_o), .cdb1_data_o(cdb1_data_o), .cdb1_dest_o(cdb1_dest_o),
        .cdb1_rob_o(cdb1_rob_o), .cdb1_fu_o(cdb1_fu_o),
        .cdb2_valid_o(cdb2_valid_o), .cdb2_data_o(cdb2_data_o), .cdb2_dest_o(cdb2_dest_o),
        .cdb2_rob_o(cdb2_rob_o), .cdb2_fu_o(cdb2_fu_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fu1_valid_i = 0; fu2_valid_i = 0; fu3_valid_i = 0;
    endtask

    initial begin
        rst_n = 0; flush_i = 0; cdb_stall_i = 0;
        idle_inputs();
        fu1_data_i = 0; fu2_data_i = 0; fu3_data_i = 0;
        fu1_dest_i = 0; fu2_dest_i = 0; fu3_dest_i = 0;
        fu1_rob_i = 0;  fu2_rob_i = 0;  fu3_rob_i = 0;

        // ---- reset state ----
        #12;
        check("rst_ready1", fu1_ready_o, 0);
        check("rst_ready3", fu3_ready_o, 0);
        check("rst_cdb1_valid", cdb1_valid_o, 0);
        check("rst_cdb2_fu", cdb2_fu_o, 0);
        check("rst_rr", dut.rr_q, 0);
        rst_n = 1;
        tick();

        // ---- single uncontended result, 2-clock latency ----
        fu1_valid_i = 1; fu1_data_i = 32'h5; fu1_dest_i = 6'd12; fu1_rob_i = 4'd3;
        #1 check("t1_ready1", fu1_ready_o, 1);
        tick();
        idle_inputs();
        check("t1_cdb1_valid_early", cdb1_valid_o, 0);
        tick();
        check("t1_cdb1_valid", cdb1_valid_o, 1);
        check("t1_cdb1_data", cdb1_data_o, 32'h5);
        check("t1_cdb1_dest", cdb1_dest_o, 12);
        check("t1_cdb1_rob", cdb1_rob_o, 3);
        check("t1_cdb1_fu", cdb1_fu_o, 1);
        check("t1_cdb2_valid", cdb2_valid_o, 0);
        check("t1_rr", dut.rr_q, 1);
        tick();
        check("t1_idle", cdb1_valid_o, 0);

        // flush pulse brings rr back to 0
        flush_i = 1;
        tick();
        flush_i = 0;
        check("fl_rr", dut.rr_q, 0);

        // ---- three-way contention ----
        fu1_valid_i = 1; fu1_data_i = 32'hA1; fu1_dest_i = 1; fu1_rob_i = 1;
        fu2_valid_i = 1; fu2_data_i = 32'hA2; fu2_dest_i = 2; fu2_rob_i = 2;
        fu3_valid_i = 1; fu3_data_i = 32'hA3; fu3_dest_i = 3; fu3_rob_i = 3;
        tick();
        fu3_valid_i = 0;
        fu1_data_i = 32'hB1; fu1_rob_i = 4;
        fu2_data_i = 32'hB2; fu2_rob_i = 5;
        #1;
        check("t2_ready1", fu1_ready_o, 1);
        check("t2_ready2", fu2_ready_o, 1);
        check("t2_ready3", fu3_ready_o, 0);
        tick();
        idle_inputs();
        check("t2a_cdb1_data", cdb1_data_o, 32'hA1);
        check("t2a_cdb1_fu", cdb1_fu_o, 1);
        check("t2a_cdb2_valid", cdb2_valid_o, 1);
        check("t2a_cdb2_data", cdb2_data_o, 32'hA2);
        check("t2a_cdb2_fu", cdb2_fu_o, 2);
        check("t2a_rr", dut.rr_q, 2);
        tick();
        check("t2b_cdb1_data", cdb1_data_o, 32'hA3);
        check("t2b_cdb1_fu", cdb1_fu_o, 3);
        check("t2b_cdb2_data", cdb2_data_o, 32'hB1);
        check("t2b_cdb2_fu", cdb2_fu_o, 1);
        check("t2b_rr", dut.rr_q, 1);
        tick();
        check("t2c_cdb1_data", cdb1_data_o, 32'hB2);
        check("t2c_cdb1_rob", cdb1_rob_o, 5);
        check("t2c_cdb1_fu", cdb1_fu_o, 2);
        check("t2c_cdb2_valid", cdb2_valid_o, 0);
        check("t2c_cdb2_data", cdb2_data_o, 0);
        check("t2c_rr", dut.rr_q, 2);
        tick();
        check("t2d_idle", cdb1_valid_o, 0);

        // ---- sustained FU2 stream ----
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                fu2_valid_i = 1; fu2_data_i = 32'h100 + i; fu2_dest_i = 6'(i); fu2_rob_i = 4'(i);
                #1 check("t3_ready2", fu2_ready_o, 1);
            end else begin
                fu2_valid_i = 0;
            end
            tick();
            if (i >= 1 && i <= 8) begin
                check("t3_cdb1_valid", cdb1_valid_o, 1);
                check("t3_cdb1_data", cdb1_data_o, 32'h100 + i - 1);
            end else if (i == 9) begin
                check("t3_end_valid", cdb1_valid_o, 0);
            end
        end

        // ---- stall holds FU3 ----
        fu3_valid_i = 1; fu3_data_i = 32'h33; fu3_dest_i = 7; fu3_rob_i = 7;
        tick();
        fu3_valid_i = 0;
        cdb_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_ready3_stall", fu3_ready_o, 0);
            check("t4_ready1_stall", fu1_ready_o, 1);
            tick();
            check("t4_cdb1_valid_stall", cdb1_valid_o, 0);
            check("t4_cdb2_valid_stall", cdb2_valid_o, 0);
        end
        cdb_stall_i = 0;
        #1 check("t4_ready3_release", fu3_ready_o, 1);
        tick();
        check("t4_cdb1_valid", cdb1_valid_o, 1);
        check("t4_cdb1_data", cdb1_data_o, 32'h33);
        check("t4_cdb1_fu", cdb1_fu_o, 3);
        tick();

        // ---- flush discards held results ----
        cdb_stall_i = 1;
        fu1_valid_i = 1; fu1_data_i = 32'h51;
        fu2_valid_i = 1; fu2_data_i = 32'h52;
        tick();
        idle_inputs();
        cdb_stall_i = 0;
        flush_i = 1;
        fu3_valid_i = 1; fu3_data_i = 32'h53;
        #1;
        check("t5_ready1_flush", fu1_ready_o, 0);
        check("t5_ready2_flush", fu2_ready_o, 0);
        check("t5_ready3_flush", fu3_ready_o, 0);
        tick();
        flush_i = 0;
        fu3_valid_i = 0;
        check("t5_cdb1_valid", cdb1_valid_o, 0);
        check("t5_rr", dut.rr_q, 0);
        tick();
        check("t5_cdb1_valid_after", cdb1_valid_o, 0);
        check("t5_cdb2_valid_after", cdb2_valid_o, 0);

        // ---- dest 0 broadcast, then async reset mid-cycle ----
        fu1_valid_i = 1; fu1_data_i = 32'h77; fu1_dest_i = 0; fu1_rob_i = 9;
        tick();
        idle_inputs();
        tick();
        check("t6_cdb1_valid", cdb1_valid_o, 1);
        check("t6_cdb1_dest", cdb1_dest_o, 0);
        check("t6_cdb1_rob", cdb1_rob_o, 9);
        #2 rst_n = 0;
        #1;
        check("t6_async_valid", cdb1_valid_o, 0);
        check("t6_async_data", cdb1_data_o, 0);
        check("t6_async_ready1", fu1_ready_o, 0);
        check("t6_async_ready2", fu2_ready_o, 0);
        tick();
        check("t6_rst_ready3", fu3_ready_o, 0);
        #2 rst_n = 1;
        #1 check("t6_ready1_after", fu1_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
